// File: rtl/axi_burst_beat_gen_pkg.sv
// Shared AXI burst types, page constant and helpers for the beat generator and address decoder.
// The rule typedef macro takes the address type so rules follow AddrWidth instead of a fixed 32 bits.
`ifndef AXI_TYPEDEF_RULE_T
`define AXI_TYPEDEF_RULE_T(name, addr_t) typedef struct packed { int unsigned idx; addr_t start_addr; addr_t end_addr; } name;
`endif

package axi_burst_beat_gen_pkg;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam burst_t BurstFixed = 2'b00;
    localparam burst_t BurstIncr  = 2'b01;
    localparam burst_t BurstWrap  = 2'b10;
    localparam burst_t BurstRsvd  = 2'b11;

    localparam int unsigned PageBits = 12;

    typedef enum logic {
        ST_IDLE,
        ST_BEAT
    } beat_state_e;

    function automatic logic [7:0] beat_bytes(input size_t size);
        return 8'd1 << size;
    endfunction

    function automatic logic wrap_len_ok(input len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address matcher: the lowest-index rule with start <= addr < end wins.
// A miss returns the default index and raises decerr.
module axi_addr_decode #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned NoRules   = 4,
    parameter int unsigned IdxWidth  = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic [AddrWidth-1:0]         i_addr,
    input  logic [NoRules*AddrWidth-1:0] i_rule_start,
    input  logic [NoRules*AddrWidth-1:0] i_rule_end,
    input  logic [NoRules*IdxWidth-1:0]  i_rule_idx,
    input  logic [IdxWidth-1:0]          i_default_idx,
    output logic [IdxWidth-1:0]          o_idx,
    output logic                         o_decerr
);

    typedef logic [AddrWidth-1:0] addr_t;
    `AXI_TYPEDEF_RULE_T(rule_t, addr_t)

    rule_t w_rules [NoRules];

    always_comb begin
        for (int r = 0; r < int'(NoRules); r++) begin
            w_rules[r].idx        = 32'(i_rule_idx[r*IdxWidth +: IdxWidth]);
            w_rules[r].start_addr = i_rule_start[r*AddrWidth +: AddrWidth];
            w_rules[r].end_addr   = i_rule_end[r*AddrWidth +: AddrWidth];
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        o_idx    = i_default_idx;
        o_decerr = 1'b1;
        for (int r = int'(NoRules) - 1; r >= 0; r--) begin
            if ((i_addr >= w_rules[r].start_addr) && (i_addr < w_rules[r].end_addr)) begin
                o_idx    = IdxWidth'(w_rules[r].idx);
                o_decerr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_burst_beat_gen.sv
// Expands one AW/AR command into per-beat addresses; first beat 1 cycle after the command handshake.
// Beats hold while beat_ready_i is low; a new command is only accepted in IDLE or on the last beat.
module axi_burst_beat_gen
    import axi_burst_beat_gen_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned NoRules   = 4,
    parameter int unsigned IdxWidth  = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [IdWidth-1:0]           cmd_id_i,
    input  logic [AddrWidth-1:0]         cmd_addr_i,
    input  len_t                         cmd_len_i,
    input  size_t                        cmd_size_i,
    input  burst_t                       cmd_burst_i,
    input  logic [NoRules*AddrWidth-1:0] rule_start_i,
    input  logic [NoRules*AddrWidth-1:0] rule_end_i,
    input  logic [NoRules*IdxWidth-1:0]  rule_idx_i,
    input  logic [IdxWidth-1:0]          default_idx_i,
    output logic                         beat_valid_o,
    input  logic                         beat_ready_i,
    output logic [IdWidth-1:0]           beat_id_o,
    output logic [AddrWidth-1:0]         beat_addr_o,
    output logic [7:0]                   beat_num_o,
    output logic                         beat_last_o,
    output logic [IdxWidth-1:0]          beat_idx_o,
    output logic                         beat_decerr_o,
    output logic                         beat_err_o
);

    localparam int unsigned DataBytes = DataWidth / 8;
    localparam int unsigned MaxSize   = $clog2(DataBytes);
    localparam int unsigned ExtWidth  = AddrWidth + 17;

    localparam logic [AddrWidth-1:0] AddrOne = 1;
    localparam logic [ExtWidth-1:0]  ExtOne  = 1;

    beat_state_e r_state, w_next_state;

    logic [IdWidth-1:0]   r_id;
    logic [AddrWidth-1:0] r_addr;
    len_t                 r_len;
    size_t                r_size;
    burst_t               r_burst;
    logic [7:0]           r_num;
    logic                 r_last;
    logic [IdxWidth-1:0]  r_idx;
    logic                 r_decerr;
    logic                 r_err;

    logic                 w_load;
    logic                 w_advance;
    logic [IdxWidth-1:0]  w_dec_idx;
    logic                 w_dec_miss;

    logic [AddrWidth-1:0] w_cmd_n;
    logic [ExtWidth-1:0]  w_ext_addr;
    logic [ExtWidth-1:0]  w_ext_n;
    logic [ExtWidth-1:0]  w_ext_end;
    logic                 w_page_cross;
    logic                 w_wrap_misalign;
    logic                 w_cmd_err;

    logic [AddrWidth-1:0] w_n;
    logic [AddrWidth-1:0] w_wrap_mask;
    logic [AddrWidth-1:0] w_next_addr;

    axi_addr_decode #(
        .AddrWidth (AddrWidth),
        .NoRules   (NoRules),
        .IdxWidth  (IdxWidth)
    ) u_decode (
        .i_addr        (cmd_addr_i),
        .i_rule_start  (rule_start_i),
        .i_rule_end    (rule_end_i),
        .i_rule_idx    (rule_idx_i),
        .i_default_idx (default_idx_i),
        .o_idx         (w_dec_idx),
        .o_decerr      (w_dec_miss)
    );

    // Last byte is computed with headroom so a burst running past 2^AddrWidth still shows a page change.
    assign w_cmd_n         = AddrWidth'(beat_bytes(cmd_size_i));
    assign w_ext_addr      = ExtWidth'(cmd_addr_i);
    assign w_ext_n         = ExtWidth'(beat_bytes(cmd_size_i));
    assign w_ext_end       = (w_ext_addr & ~(w_ext_n - ExtOne))
                           + ((ExtWidth'(cmd_len_i) + ExtOne) << cmd_size_i) - ExtOne;
    assign w_page_cross    = (w_ext_end >> PageBits) != (w_ext_addr >> PageBits);
    assign w_wrap_misalign = (cmd_addr_i & (w_cmd_n - AddrOne)) != '0;

    assign w_cmd_err = (cmd_burst_i == BurstRsvd)
                    || (32'(cmd_size_i) > MaxSize)
                    || ((cmd_burst_i == BurstWrap) && (!wrap_len_ok(cmd_len_i) || w_wrap_misalign))
                    || ((cmd_burst_i == BurstIncr) && w_page_cross);

    assign w_n         = AddrWidth'(beat_bytes(r_size));
    assign w_wrap_mask = ((AddrWidth'(r_len) + AddrOne) << r_size) - AddrOne;

    // Errored bursts keep the start address so the beat count still matches the data channel.
    always_comb begin
        w_next_addr = r_addr;
        if (!r_err) begin
            case (r_burst)
                BurstIncr: w_next_addr = (r_addr & ~(w_n - AddrOne)) + w_n;
                BurstWrap: w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_n) & w_wrap_mask);
                default:   w_next_addr = r_addr;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready_o  = 1'b0;
        beat_valid_o = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_load       = 1'b1;
                    w_next_state = ST_BEAT;
                end
            end
            ST_BEAT: begin
                beat_valid_o = 1'b1;
                if (beat_ready_i) begin
                    if (r_last) begin
                        cmd_ready_o = 1'b1;
                        if (cmd_valid_i) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_num    <= '0;
            r_last   <= 1'b0;
            r_idx    <= '0;
            r_decerr <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_id     <= cmd_id_i;
            r_addr   <= cmd_addr_i;
            r_len    <= cmd_len_i;
            r_size   <= cmd_size_i;
            r_burst  <= cmd_burst_i;
            r_num    <= '0;
            r_last   <= (cmd_len_i == 8'd0);
            r_idx    <= w_dec_idx;
            r_decerr <= w_dec_miss;
            r_err    <= w_cmd_err;
        end else if (w_advance) begin
            r_num    <= r_num + 8'd1;
            r_last   <= ((r_num + 8'd1) == r_len);
            r_addr   <= w_next_addr;
        end
    end

    assign beat_id_o     = r_id;
    assign beat_addr_o   = r_addr;
    assign beat_num_o    = r_num;
    assign beat_last_o   = r_last;
    assign beat_idx_o    = r_idx;
    assign beat_decerr_o = r_decerr;
    assign beat_err_o    = r_err;

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Directed bench for axi_burst_beat_gen: burst address sequences, error flags, decode and handshake timing.
module tb_axi_burst_beat_gen;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [3:0]   cmd_id_i = '0;
    logic [31:0]  cmd_addr_i = '0;
    logic [7:0]   cmd_len_i = '0;
    logic [2:0]   cmd_size_i = '0;
    logic [1:0]   cmd_burst_i = '0;
    logic [127:0] rule_start_i;
    logic [127:0] rule_end_i;
    logic [7:0]   rule_idx_i;
    logic [1:0]   default_idx_i;
    logic         beat_valid_o;
    logic         beat_ready_i = 1'b1;
    logic [3:0]   beat_id_o;
    logic [31:0]  beat_addr_o;
    logic [7:0]   beat_num_o;
    logic         beat_last_o;
    logic [1:0]   beat_idx_o;
    logic         beat_decerr_o;
    logic         beat_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // rule0 [0x0,0x1000)->1, rule1 [0x800,0x2000)->2, rule2 [0x2000,0x3000)->0, rule3 empty; miss -> 3
    assign rule_start_i  = {32'h0, 32'h2000, 32'h800, 32'h0};
    assign rule_end_i    = {32'h0, 32'h3000, 32'h2000, 32'h1000};
    assign rule_idx_i    = {2'd0, 2'd0, 2'd2, 2'd1};
    assign default_idx_i = 2'd3;

    always #5 clk_i = ~clk_i;

    axi_burst_beat_gen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_id_i      (cmd_id_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_len_i     (cmd_len_i),
        .cmd_size_i    (cmd_size_i),
        .cmd_burst_i   (cmd_burst_i),
        .rule_start_i  (rule_start_i),
        .rule_end_i    (rule_end_i),
        .rule_idx_i    (rule_idx_i),
        .default_idx_i (default_idx_i),
        .beat_valid_o  (beat_valid_o),
        .beat_ready_i  (beat_ready_i),
        .beat_id_o     (beat_id_o),
        .beat_addr_o   (beat_addr_o),
        .beat_num_o    (beat_num_o),
        .beat_last_o   (beat_last_o),
        .beat_idx_o    (beat_idx_o),
        .beat_decerr_o (beat_decerr_o),
        .beat_err_o    (beat_err_o)
    );

    task automatic drive_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk_i);
        cmd_id_i    = id;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_size_i  = size;
        cmd_burst_i = burst;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %0b want 0", beat_valid_o);
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %0b want 1", cmd_ready_o);
        end
        n_checks++;
        if ({beat_id_o, beat_addr_o, beat_num_o, beat_last_o, beat_idx_o, beat_decerr_o, beat_err_o} !== 50'd0) begin
            n_errors++;
            $display("FAIL reset_fields: id=%h addr=%h num=%0d last=%0b idx=%0d decerr=%0b err=%0b want all 0",
                     beat_id_o, beat_addr_o, beat_num_o, beat_last_o, beat_idx_o, beat_decerr_o, beat_err_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_incr;
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
        beat_ready_i = 1'b1;
        drive_cmd(4'h5, 32'h1004, 8'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o} !== {1'b1, exp_addr[k], 8'(k), (k == 3), 1'b0}) begin
                n_errors++;
                $display("FAIL incr_beat%0d: valid=%0b addr=%h num=%0d last=%0b err=%0b want addr=%h num=%0d last=%0b err=0",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o, exp_addr[k], k, (k == 3));
            end
            if (k == 0) begin
                n_checks++;
                if ({beat_id_o, beat_idx_o, beat_decerr_o} !== {4'h5, 2'd2, 1'b0}) begin
                    n_errors++;
                    $display("FAIL incr_meta: id=%h idx=%0d decerr=%0b want id=5 idx=2 decerr=0", beat_id_o, beat_idx_o, beat_decerr_o);
                end
            end
        end
        @(negedge clk_i);
        n_checks++;
        if ({beat_valid_o, cmd_ready_o} !== 2'b01) begin
            n_errors++; $display("FAIL incr_idle: valid=%0b ready=%0b want valid=0 ready=1", beat_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h1038, 32'h1020, 32'h1028, 32'h1030};
        drive_cmd(4'h6, 32'h1038, 8'd3, 3'd3, 2'b10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o} !== {1'b1, exp_addr[k], 8'(k), (k == 3), 1'b0}) begin
                n_errors++;
                $display("FAIL wrap_beat%0d: valid=%0b addr=%h num=%0d last=%0b err=%0b want addr=%h num=%0d last=%0b err=0",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o, exp_addr[k], k, (k == 3));
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL wrap_end: valid=%0b want 0", beat_valid_o);
        end
    endtask

    task automatic test_fixed_stall;
        int exp_num;
        exp_num = 0;
        beat_ready_i = 1'b0;
        drive_cmd(4'h9, 32'h2000, 8'd2, 3'd2, 2'b00);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o, beat_decerr_o} !==
                {1'b1, 32'h2000, 8'(exp_num), (exp_num == 2), 4'h9, 1'b0}) begin
                n_errors++;
                $display("FAIL fixed_cycle%0d: valid=%0b addr=%h num=%0d last=%0b id=%h decerr=%0b want addr=00002000 num=%0d last=%0b id=9 decerr=0",
                         c, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o, beat_decerr_o, exp_num, (exp_num == 2));
            end
            beat_ready_i = (c % 2 == 1);
            if (beat_ready_i) exp_num++;
        end
        @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL fixed_end: valid=%0b want 0 after 3 beats", beat_valid_o);
        end
        beat_ready_i = 1'b1;
    endtask

    task automatic test_page;
        logic [31:0] exp_ok [2];
        exp_ok = '{32'hFF0, 32'hFF8};
        drive_cmd(4'h1, 32'hFF0, 8'd1, 3'd3, 2'b01);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_last_o, beat_err_o, beat_idx_o} !== {1'b1, exp_ok[k], (k == 1), 1'b0, 2'd1}) begin
                n_errors++;
                $display("FAIL page_ok_beat%0d: valid=%0b addr=%h last=%0b err=%0b idx=%0d want addr=%h last=%0b err=0 idx=1",
                         k, beat_valid_o, beat_addr_o, beat_last_o, beat_err_o, beat_idx_o, exp_ok[k], (k == 1));
            end
        end
        @(negedge clk_i);
        drive_cmd(4'h2, 32'hFFC, 8'd1, 3'd3, 2'b01);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o} !== {1'b1, 32'hFFC, 8'(k), (k == 1), 1'b1}) begin
                n_errors++;
                $display("FAIL page_cross_beat%0d: valid=%0b addr=%h num=%0d last=%0b err=%0b want addr=00000ffc num=%0d last=%0b err=1",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o, k, (k == 1));
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL page_cross_end: valid=%0b want 0", beat_valid_o);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addr_tab [3];
        logic [2:0]  size_tab [3];
        logic [1:0]  burst_tab [3];
        drive_cmd(4'h3, 32'h1000, 8'd2, 3'd2, 2'b10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o} !== {1'b1, 32'h1000, 8'(k), (k == 2), 1'b1}) begin
                n_errors++;
                $display("FAIL wraplen_beat%0d: valid=%0b addr=%h num=%0d last=%0b err=%0b want addr=00001000 num=%0d last=%0b err=1",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o, k, (k == 2));
            end
        end
        // reserved burst, oversize beat, misaligned WRAP: each a single-beat burst with err set
        addr_tab  = '{32'h1100, 32'h1100, 32'h1002};
        size_tab  = '{3'd2, 3'd4, 3'd2};
        burst_tab = '{2'b11, 2'b01, 2'b10};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            drive_cmd(4'h4, addr_tab[t], (t == 2) ? 8'd1 : 8'd0, size_tab[t], burst_tab[t]);
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_err_o} !== {1'b1, addr_tab[t], 1'b1}) begin
                n_errors++;
                $display("FAIL err_case%0d: valid=%0b addr=%h err=%0b want valid=1 addr=%h err=1",
                         t, beat_valid_o, beat_addr_o, beat_err_o, addr_tab[t]);
            end
            if (t == 2) @(negedge clk_i);
        end
        @(negedge clk_i);
    endtask

    task automatic test_decode;
        logic [31:0] addr_tab [3];
        logic [1:0]  idx_tab [3];
        logic        miss_tab [3];
        addr_tab = '{32'h900, 32'h1800, 32'h3000};
        idx_tab  = '{2'd1, 2'd2, 2'd3};
        miss_tab = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            drive_cmd(4'h8, addr_tab[t], 8'd0, 3'd2, 2'b01);
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_idx_o, beat_decerr_o, beat_last_o} !== {1'b1, idx_tab[t], miss_tab[t], 1'b1}) begin
                n_errors++;
                $display("FAIL decode_%h: valid=%0b idx=%0d decerr=%0b last=%0b want idx=%0d decerr=%0b last=1",
                         addr_tab[t], beat_valid_o, beat_idx_o, beat_decerr_o, beat_last_o, idx_tab[t], miss_tab[t]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back;
        drive_cmd(4'h1, 32'h100, 8'd1, 3'd2, 2'b01);
        cmd_id_i    = 4'h2;
        cmd_addr_i  = 32'h200;
        cmd_len_i   = 8'd0;
        cmd_size_i  = 3'd2;
        cmd_burst_i = 2'b00;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({beat_valid_o, beat_addr_o, beat_id_o, cmd_ready_o} !== {1'b1, 32'h100, 4'h1, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_a0: valid=%0b addr=%h id=%h ready=%0b want valid=1 addr=00000100 id=1 ready=0",
                     beat_valid_o, beat_addr_o, beat_id_o, cmd_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({beat_valid_o, beat_addr_o, beat_last_o, cmd_ready_o} !== {1'b1, 32'h104, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL b2b_a1: valid=%0b addr=%h last=%0b ready=%0b want valid=1 addr=00000104 last=1 ready=1",
                     beat_valid_o, beat_addr_o, beat_last_o, cmd_ready_o);
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o} !== {1'b1, 32'h200, 8'd0, 1'b1, 4'h2}) begin
            n_errors++;
            $display("FAIL b2b_b0: valid=%0b addr=%h num=%0d last=%0b id=%h want valid=1 addr=00000200 num=0 last=1 id=2",
                     beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL b2b_end: valid=%0b want 0", beat_valid_o);
        end
    endtask

    task automatic test_len255;
        drive_cmd(4'hA, 32'h0, 8'd255, 3'd0, 2'b01);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o} !== {1'b1, 32'(k), 8'(k), (k == 255), 1'b0}) begin
                n_errors++;
                $display("FAIL len255_beat%0d: valid=%0b addr=%h num=%0d last=%0b err=%0b want addr=%h num=%0d last=%0b err=0",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_err_o, k, k, (k == 255));
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (beat_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL len255_end: valid=%0b want 0 after 256 beats", beat_valid_o);
        end
    endtask

    task automatic test_reset_mid;
        drive_cmd(4'hB, 32'h1000, 8'd7, 3'd2, 2'b01);
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({beat_valid_o, beat_num_o, beat_addr_o, cmd_ready_o} !== {1'b0, 8'd0, 32'h0, 1'b1}) begin
            n_errors++;
            $display("FAIL midrst_async: valid=%0b num=%0d addr=%h ready=%0b want valid=0 num=0 addr=0 ready=1",
                     beat_valid_o, beat_num_o, beat_addr_o, cmd_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive_cmd(4'h7, 32'h1040, 8'd1, 3'd2, 2'b01);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o} !== {1'b1, 32'h1040 + 32'(4 * k), 8'(k), (k == 1), 4'h7}) begin
                n_errors++;
                $display("FAIL midrst_restart%0d: valid=%0b addr=%h num=%0d last=%0b id=%h want addr=%h num=%0d last=%0b id=7",
                         k, beat_valid_o, beat_addr_o, beat_num_o, beat_last_o, beat_id_o, 32'h1040 + 32'(4 * k), k, (k == 1));
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_page();
        test_errors();
        test_decode();
        test_back_to_back();
        test_len255();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
